// File: rtl/lane_field_pkg.sv
// Lane record, screen geometry and small helpers shared by the lane field
// and the vertical scroll stage.
package lane_field_pkg;

  localparam int unsigned LANE_H    = 60;
  localparam int unsigned SCREEN_W  = 640;
  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned MOVE_AMT  = 2;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef struct packed {
    logic       is_road;
    logic       dir;
    logic [1:0] speed;
    logic [9:0] car_x;
  } lane_t;

  // (a - b) modulo w, for a and b already in [0, w)
  function automatic logic [10:0] circ_dist(input logic [9:0]  a,
                                            input logic [9:0]  b,
                                            input logic [10:0] w);
    logic [10:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, a} + w - {1'b0, b};
    end
    return d;
  endfunction

  function automatic lane_t move_car(input lane_t l, input logic [10:0] w);
    lane_t       r;
    logic [10:0] x;
    logic [10:0] s;
    r = l;
    x = {1'b0, l.car_x};
    s = {9'd0, l.speed};
    if (l.dir) begin
      if (x + s >= w) begin
        x = x + s - w;
      end else begin
        x = x + s;
      end
    end else begin
      if (x < s) begin
        x = x + w - s;
      end else begin
        x = x - s;
      end
    end
    r.car_x = x[9:0];
    return r;
  endfunction

endpackage

// File: rtl/lane_field_lfsr.sv
// Free-running 16-bit Galois LFSR that supplies the attributes of newly spawned lanes.
module lane_lfsr
  import lane_field_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state_o
);

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = {1'b0, state_q[15:1]};
    if (state_q[0]) begin
      state_d = state_d ^ LFSR_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/lane_field.sv
// Scrolling stack of grass/road lanes with moving cars: spawns lanes from an
// LFSR, renders road/car pixel flags and latches a sticky player collision.
module lane_field #(
  parameter int unsigned NUM_LANES    = 9,
  parameter int unsigned LANE_H       = lane_field_pkg::LANE_H,
  parameter int unsigned MOVE_AMT     = lane_field_pkg::MOVE_AMT,
  parameter int unsigned SCREEN_W     = lane_field_pkg::SCREEN_W,
  parameter int unsigned CAR_W        = 40,
  parameter int unsigned PLAYER_LANE  = 7,
  parameter int unsigned PLAYER_W     = 32,
  parameter int unsigned MAX_ROAD_RUN = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_followers,
  input  logic       frame_tick,
  input  logic [9:0] player_x,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       road_px,
  output logic       car_px,
  output logic       hit,
  output logic       lane_spawn
);

  import lane_field_pkg::*;

  localparam int unsigned OFF_W  = $clog2(LANE_H);
  localparam int unsigned OFF_SW = OFF_W + 1;
  localparam int unsigned RUN_W  = $clog2(MAX_ROAD_RUN + 1);

  localparam logic [10:0]       W11       = 11'(SCREEN_W);
  localparam logic [OFF_SW-1:0] LANE_H_S  = OFF_SW'(LANE_H);
  localparam logic [OFF_SW-1:0] MOVE_S    = OFF_SW'(MOVE_AMT);
  localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(MAX_ROAD_RUN);

  lane_t lanes_q [NUM_LANES];
  lane_t lanes_d [NUM_LANES];
  lane_t moved   [NUM_LANES];
  lane_t new_lane;

  logic [OFF_W-1:0]  off_q, off_d;
  logic [OFF_SW-1:0] off_sum, off_wrap;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              hit_q, spawn_q, road_q, car_q;
  logic              spawn_d, road_d, car_d, overlap;

  logic [15:0] lfsr;
  logic        unused_lfsr_bits;

  lane_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .state_o(lfsr)
  );

  assign unused_lfsr_bits = ^lfsr[15:14];

  always_comb begin
    new_lane         = '0;
    new_lane.is_road = (lfsr[0] | lfsr[1]) && (run_q != RUN_LIMIT);
    new_lane.dir     = lfsr[2];
    new_lane.speed   = (lfsr[4:3] == 2'd0) ? 2'd1 : lfsr[4:3];
    new_lane.car_x   = {1'b0, lfsr[13:5]};
  end

  // Motion is applied before the shift so shifted lanes carry moved cars,
  // while the freshly spawned lane takes raw LFSR values.
  always_comb begin
    moved    = lanes_q;
    lanes_d  = lanes_q;
    off_d    = off_q;
    run_d    = run_q;
    spawn_d  = 1'b0;
    off_sum  = OFF_SW'(off_q) + MOVE_S;
    off_wrap = off_sum - LANE_H_S;
    if (!hit_q) begin
      if (frame_tick) begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
          if (lanes_q[i].is_road) begin
            moved[i] = move_car(lanes_q[i], W11);
          end
        end
      end
      lanes_d = moved;
      if (move_followers) begin
        if (off_sum >= LANE_H_S) begin
          off_d   = off_wrap[OFF_W-1:0];
          spawn_d = 1'b1;
          for (int unsigned i = 1; i < NUM_LANES; i++) begin
            lanes_d[i] = moved[i-1];
          end
          lanes_d[0] = new_lane;
          run_d      = new_lane.is_road ? run_q + 1'b1 : '0;
        end else begin
          off_d = off_sum[OFF_W-1:0];
        end
      end
    end
  end

  logic [10:0] row_t;
  logic [10:0] pix_dx;
  lane_t       sel;

  // Row-to-lane lookup as a compare chain against lane top edges.
  always_comb begin
    row_t = {1'b0, pix_y} + 11'(LANE_H) - 11'(off_q);
    sel   = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      if (row_t >= 11'(k * LANE_H)) begin
        sel = lanes_q[k];
      end
    end
    pix_dx = circ_dist(pix_x, sel.car_x, W11);
    road_d = sel.is_road && (pix_y < 10'(SCREEN_H));
    car_d  = road_d && (pix_dx < 11'(CAR_W));
  end

  lane_t       pl;
  logic [10:0] car_from_player;
  logic [10:0] player_from_car;

  // Two wrapped intervals meet exactly when one starts inside the other.
  always_comb begin
    pl              = lanes_q[PLAYER_LANE];
    car_from_player = circ_dist(pl.car_x, player_x, W11);
    player_from_car = circ_dist(player_x, pl.car_x, W11);
    overlap         = pl.is_road &&
                      ((car_from_player < 11'(PLAYER_W)) || (player_from_car < 11'(CAR_W)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        lanes_q[i].is_road <= (i == 1) || (i == 3) || (i == 5);
        lanes_q[i].dir     <= ((i >> 1) & 1) != 0;
        lanes_q[i].speed   <= 2'd1;
        lanes_q[i].car_x   <= 10'(i * 64);
      end
      off_q   <= '0;
      run_q   <= '0;
      hit_q   <= 1'b0;
      spawn_q <= 1'b0;
      road_q  <= 1'b0;
      car_q   <= 1'b0;
    end else begin
      lanes_q <= lanes_d;
      off_q   <= off_d;
      run_q   <= run_d;
      hit_q   <= hit_q | overlap;
      spawn_q <= spawn_d;
      road_q  <= road_d;
      car_q   <= car_d;
    end
  end

  assign road_px    = road_q;
  assign car_px     = car_q;
  assign hit        = hit_q;
  assign lane_spawn = spawn_q;

endmodule

// File: tb/tb_lane_field.sv
// Randomized bench for lane_field against a cycle-level arithmetic model of the lane stack.
module tb_lane_field;

  localparam int W = 640, LH = 60, CW = 40, PW = 32, NL = 9, PL = 7, MA = 2, MAXRUN = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       move_followers = 1'b0;
  logic       frame_tick = 1'b0;
  logic [9:0] player_x = '0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       road_px, car_px, hit, lane_spawn;

  int vectors = 0;
  int miscompares = 0;

  bit m_road[NL];
  bit m_dir[NL];
  int m_spd[NL];
  int m_cx[NL];
  int m_off, m_run, m_lfsr;
  bit m_hit, m_spawn, m_rpx, m_cpx;
  bit aim_hit = 1'b0;

  lane_field dut (
    .clk           (clk),
    .reset         (reset),
    .move_followers(move_followers),
    .frame_tick    (frame_tick),
    .player_x      (player_x),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .road_px       (road_px),
    .car_px        (car_px),
    .hit           (hit),
    .lane_spawn    (lane_spawn)
  );

  always #20 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic bit covers(int start, int width, int x);
    for (int k = 0; k < width; k++) if ((start + k) % W == x) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit boxes_meet(int p, int c);
    for (int k = 0; k < PW; k++) if (covers(c, CW, (p + k) % W)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_road[i] = (i == 1) || (i == 3) || (i == 5);
      m_dir[i]  = ((i / 2) % 2) == 1;
      m_spd[i]  = 1;
      m_cx[i]   = i * 64;
    end
    m_off = 0; m_run = 0; m_lfsr = 'hACE1;
    m_hit = 0; m_spawn = 0; m_rpx = 0; m_cpx = 0;
  endfunction

  // Drives one clock with the given pulses and advances the model alongside.
  task automatic step(input bit mf, input bit ft);
    bit n_road[NL]; bit n_dir[NL]; int n_spd[NL]; int n_cx[NL];
    int n_off, n_run, n_lfsr, k;
    bit n_hit, n_spawn, n_rpx, n_cpx, new_road;
    if (!aim_hit) begin
      if (m_road[PL]) player_x = 10'((m_cx[PL] + CW + int'($urandom_range(0, W - CW - PW))) % W);
      else            player_x = 10'($urandom_range(0, W - 1));
    end
    move_followers = mf;
    frame_tick = ft;
    n_road = m_road; n_dir = m_dir; n_spd = m_spd; n_cx = m_cx;
    n_off = m_off; n_run = m_run; n_hit = m_hit; n_spawn = 0;
    n_rpx = 0; n_cpx = 0;
    if (int'(pix_y) < 480) begin
      k = (int'(pix_y) + LH - m_off) / LH;
      n_rpx = m_road[k];
      n_cpx = m_road[k] && covers(m_cx[k], CW, int'(pix_x));
    end
    if (m_road[PL] && boxes_meet(int'(player_x), m_cx[PL])) n_hit = 1;
    if (!m_hit) begin
      if (ft) begin
        for (int i = 0; i < NL; i++)
          if (n_road[i]) n_cx[i] = n_dir[i] ? (n_cx[i] + n_spd[i]) % W : (n_cx[i] - n_spd[i] + W) % W;
      end
      if (mf) begin
        if (m_off + MA >= LH) begin
          n_off = m_off + MA - LH;
          n_spawn = 1;
          for (int i = NL - 1; i > 0; i--) begin
            n_road[i] = n_road[i-1]; n_dir[i] = n_dir[i-1]; n_spd[i] = n_spd[i-1]; n_cx[i] = n_cx[i-1];
          end
          new_road  = ((m_lfsr % 4) != 0) && (m_run != MAXRUN);
          n_road[0] = new_road;
          n_dir[0]  = ((m_lfsr / 4) % 2) == 1;
          n_spd[0]  = (m_lfsr / 8) % 4;
          if (n_spd[0] == 0) n_spd[0] = 1;
          n_cx[0]   = (m_lfsr / 32) % 512;
          n_run     = new_road ? m_run + 1 : 0;
        end else begin
          n_off = m_off + MA;
        end
      end
    end
    n_lfsr = (m_lfsr / 2) ^ (((m_lfsr % 2) == 1) ? 'hB400 : 0);
    @(posedge clk);
    #1;
    move_followers = 0;
    frame_tick = 0;
    if (reset) begin
      model_reset();
    end else begin
      m_road = n_road; m_dir = n_dir; m_spd = n_spd; m_cx = n_cx;
      m_off = n_off; m_run = n_run; m_lfsr = n_lfsr;
      m_hit = n_hit; m_spawn = n_spawn; m_rpx = n_rpx; m_cpx = n_cpx;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    step(1, 1);
    step(0, 0);
    vectors++; if (hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit: got %b expected 0", hit); end
    vectors++; if (lane_spawn !== 1'b0) begin miscompares++; $display("FAIL reset_spawn: got %b expected 0", lane_spawn); end
    vectors++; if (road_px !== 1'b0 || car_px !== 1'b0)
      begin miscompares++; $display("FAIL reset_pix: got %b%b expected 00", road_px, car_px); end
    reset = 0;
    for (int k = 1; k < 8; k++) begin
      pix_y = 10'((k - 1) * LH + 30);
      pix_x = 10'(m_cx[k]);
      step(0, 0);
      vectors++;
      if (road_px !== m_rpx || car_px !== m_cpx) begin
        miscompares++;
        $display("FAIL reset_lane%0d: road/car got %b/%b expected %b/%b", k, road_px, car_px, m_rpx, m_cpx);
      end
    end
  endtask

  task automatic test_scroll();
    int ys[4] = '{57, 58, 117, 118};
    for (int n = 1; n <= 29; n++) begin
      step(1, 0);
      vectors++; if (lane_spawn !== 1'b0) begin miscompares++; $display("FAIL scroll_nospawn%0d: got %b expected 0", n, lane_spawn); end
    end
    for (int i = 0; i < 4; i++) begin
      pix_y = 10'(ys[i]);
      pix_x = 10'($urandom_range(0, W - 1));
      step(0, 0);
      vectors++;
      if (road_px !== m_rpx) begin miscompares++; $display("FAIL scroll_row%0d: road_px got %b expected %b", ys[i], road_px, m_rpx); end
    end
    step(1, 0);
    vectors++; if (lane_spawn !== 1'b1 || m_spawn !== 1'b1) begin miscompares++; $display("FAIL scroll_spawn: got %b expected 1", lane_spawn); end
    pix_y = 10'd90;
    pix_x = 10'd64;
    step(0, 0);
    vectors++; if (lane_spawn !== 1'b0) begin miscompares++; $display("FAIL scroll_spawn_len: got %b expected 0", lane_spawn); end
    vectors++; if (road_px !== m_rpx || car_px !== m_cpx)
      begin miscompares++; $display("FAIL scroll_lane2_car: got %b/%b expected %b/%b", road_px, car_px, m_rpx, m_cpx); end
    pix_x = 10'd63;
    step(0, 0);
    vectors++; if (car_px !== m_cpx) begin miscompares++; $display("FAIL scroll_lane2_edge: got %b expected %b", car_px, m_cpx); end
  endtask

  task automatic test_wrap();
    int found = 0;
    int row;
    for (int t = 0; t < 800 && found < 6; t++) begin
      step(0, 1);
      for (int k = 1; k < NL; k++) begin
        row = (k - 1) * LH + m_off + 5;
        if (found < 6 && m_road[k] && m_cx[k] > W - CW && row < 480) begin
          pix_y = 10'(row);
          pix_x = 10'd0;
          step(0, 0);
          vectors++; if (car_px !== m_cpx) begin miscompares++; $display("FAIL wrap_left_lane%0d: got %b expected %b", k, car_px, m_cpx); end
          pix_x = 10'(W - 1);
          step(0, 0);
          vectors++; if (car_px !== m_cpx) begin miscompares++; $display("FAIL wrap_right_lane%0d: got %b expected %b", k, car_px, m_cpx); end
          found++;
        end
      end
    end
    vectors++; if (found == 0) begin miscompares++; $display("FAIL wrap_budget: found %0d wrapped cars, expected at least 1", found); end
  endtask

  task automatic test_road_run();
    int spawns = 0;
    int cycles = 0;
    while (spawns < 24 && cycles < 2000) begin
      if (m_spawn) pix_y = 10'd30;
      else         pix_y = 10'($urandom_range(0, 479));
      pix_x = 10'($urandom_range(0, W - 1));
      step(1, 0);
      cycles++;
      vectors++; if (lane_spawn !== m_spawn) begin miscompares++; $display("FAIL run_spawn: got %b expected %b", lane_spawn, m_spawn); end
      vectors++; if (road_px !== m_rpx || car_px !== m_cpx)
        begin miscompares++; $display("FAIL run_pix y=%0d: got %b/%b expected %b/%b", pix_y, road_px, car_px, m_rpx, m_cpx); end
      if (m_spawn) spawns++;
    end
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    int y0;
    while (m_off != LH - MA && guard < 100) begin step(1, 0); guard++; end
    step(1, 1);
    vectors++; if (lane_spawn !== 1'b1) begin miscompares++; $display("FAIL simul_spawn: got %b expected 1", lane_spawn); end
    for (int n = 0; n < 20; n++) step(1, 0);
    for (int k = 0; k < NL; k++) begin
      y0 = (k - 1) * LH + m_off;
      if (y0 < 0) y0 = 0;
      if (y0 < 480) begin
        for (int j = 0; j < 2; j++) begin
          pix_y = 10'(y0);
          pix_x = 10'((m_cx[k] + W - j) % W);
          step(0, 0);
          vectors++; if (road_px !== m_rpx || car_px !== m_cpx)
            begin miscompares++; $display("FAIL simul_lane%0d_%0d: got %b/%b expected %b/%b", k, j, road_px, car_px, m_rpx, m_cpx); end
        end
      end
    end
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      pix_y = 10'($urandom_range(0, 511));
      pix_x = 10'($urandom_range(0, W - 1));
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      vectors++; if (road_px !== m_rpx || car_px !== m_cpx)
        begin miscompares++; $display("FAIL random_pix x=%0d y=%0d: got %b/%b expected %b/%b", pix_x, pix_y, road_px, car_px, m_rpx, m_cpx); end
      vectors++; if (lane_spawn !== m_spawn || hit !== m_hit)
        begin miscompares++; $display("FAIL random_flags: spawn/hit got %b/%b expected %b/%b", lane_spawn, hit, m_spawn, m_hit); end
    end
  endtask

  task automatic test_hit();
    int guard = 0;
    int c, y0;
    while (!(m_road[PL] && m_off == 40) && guard < 3000) begin
      step(1, $urandom_range(0, 3) == 0);
      guard++;
    end
    vectors++; if (guard >= 3000) begin miscompares++; $display("FAIL hit_setup: budget %0d cycles exhausted, expected road in player lane", guard); end
    aim_hit = 1;
    c = m_cx[PL];
    player_x = 10'((c + CW) % W);
    step(0, 0);
    vectors++; if (hit !== m_hit) begin miscompares++; $display("FAIL hit_miss_right: got %b expected %b", hit, m_hit); end
    player_x = 10'((c + W - PW) % W);
    step(0, 0);
    vectors++; if (hit !== m_hit) begin miscompares++; $display("FAIL hit_miss_left: got %b expected %b", hit, m_hit); end
    player_x = ($urandom_range(0, 1) == 1) ? 10'((c + CW - 1) % W) : 10'((c + W - PW + 1) % W);
    step(0, 0);
    vectors++; if (hit !== 1'b1 || m_hit !== 1'b1) begin miscompares++; $display("FAIL hit_set: got %b expected 1", hit); end
    aim_hit = 0;
    for (int n = 0; n < 10; n++) step(0, 1);
    for (int n = 0; n < 30; n++) begin
      step(1, 0);
      vectors++; if (lane_spawn !== 1'b0 || hit !== 1'b1)
        begin miscompares++; $display("FAIL hit_frozen%0d: spawn/hit got %b/%b expected 0/1", n, lane_spawn, hit); end
    end
    for (int k = 0; k < NL; k++) begin
      y0 = (k - 1) * LH + m_off;
      for (int j = 0; j < 2; j++) begin
        if (y0 - j >= 0 && y0 - j < 480) begin
          pix_y = 10'(y0 - j);
          pix_x = 10'(m_cx[k]);
          step(0, 0);
          vectors++; if (road_px !== m_rpx || car_px !== m_cpx)
            begin miscompares++; $display("FAIL hit_pix_lane%0d_%0d: got %b/%b expected %b/%b", k, j, road_px, car_px, m_rpx, m_cpx); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1;
    step(1, 1);
    vectors++; if (hit !== 1'b0 || lane_spawn !== 1'b0)
      begin miscompares++; $display("FAIL midreset_flags: hit/spawn got %b/%b expected 0/0", hit, lane_spawn); end
    vectors++; if (road_px !== 1'b0 || car_px !== 1'b0)
      begin miscompares++; $display("FAIL midreset_pix: got %b/%b expected 0/0", road_px, car_px); end
    reset = 0;
    for (int k = 1; k < 8; k++) begin
      pix_y = 10'((k - 1) * LH);
      pix_x = 10'(m_cx[k]);
      step(0, 0);
      vectors++; if (road_px !== m_rpx || car_px !== m_cpx)
        begin miscompares++; $display("FAIL midreset_lane%0d: got %b/%b expected %b/%b", k, road_px, car_px, m_rpx, m_cpx); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_scroll();
    test_wrap();
    test_road_run();
    test_simultaneous();
    test_random(1500);
    test_hit();
    test_reset_mid();
    test_random(500);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
